// File: rtl/sun_pll_fbdiv_lock.sv
// sun_pll_fbdiv_lock: programmable feedback divider for the ring-oscillator PLL
// with a digital frequency-lock detector. Everything runs on CK. CK_REF is
// synchronised and its period is measured in CK cycles, then compared against
// the active divide ratio.
module sun_pll_fbdiv_lock #(
  parameter int NW       = 8,
  parameter int N_RST    = 32,
  parameter int N_MIN    = 2,
  parameter int PW       = 10,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 16
) (
  input  logic          CK,
  input  logic          PWRUP_1V8,
  input  logic [NW-1:0] DIV_N,
  input  logic          CK_REF,
  output logic          CK_FB,
  output logic          LOCK,
  output logic [PW-1:0] PERIOD,
  output logic [NW-1:0] N_ACT
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [PW-1:0] PC_MAX = {PW{1'b1}};

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Divider state
  logic [NW-1:0] cnt_r;
  logic [NW-1:0] n_act_r;
  logic          ck_fb_r;

  // Reference synchroniser and edge detector
  logic          ref_meta_r;
  logic          ref_sync_r;
  logic          ref_dly_r;

  // Measurement and lock state
  logic [PW-1:0] pc_r;
  logic [PW-1:0] period_r;
  logic          armed_r;
  logic [GW-1:0] gc_r;
  lock_state_t   state_r;
  logic          lock_r;

  // Combinational helpers
  logic          wrap_s;
  logic [NW-1:0] div_clamp_s;
  logic [NW-1:0] cnt_nxt_s;
  logic [NW-1:0] n_nxt_s;
  logic          n_change_s;
  logic          fb_nxt_s;
  logic          ref_rise_s;
  logic          pc_sat_s;
  logic [PW-1:0] pc_inc_s;
  logic [PW:0]   diff_s;
  logic [PW:0]   abs_s;
  logic          good_s;
  logic          sat_event_s;

  // Next divider count, ratio reload at wrap and next CK_FB level
  always_comb begin
    wrap_s      = (cnt_r == (n_act_r - NW'(1)));
    div_clamp_s = DIV_N;
    cnt_nxt_s   = cnt_r + NW'(1);
    n_nxt_s     = n_act_r;
    if (DIV_N < NW'(N_MIN)) begin
      div_clamp_s = NW'(N_MIN);
    end else begin
      div_clamp_s = DIV_N;
    end
    if (wrap_s) begin
      cnt_nxt_s = {NW{1'b0}};
      n_nxt_s   = div_clamp_s;
    end else begin
      cnt_nxt_s = cnt_r + NW'(1);
      n_nxt_s   = n_act_r;
    end
    n_change_s = wrap_s && (div_clamp_s != n_act_r);
    if (cnt_nxt_s < (n_nxt_s >> 1)) begin
      fb_nxt_s = 1'b0;
    end else begin
      fb_nxt_s = 1'b1;
    end
  end

  // Reference edge, saturating period count and the good/bad verdict
  always_comb begin
    ref_rise_s = ref_sync_r & ~ref_dly_r;
    pc_sat_s   = (pc_r == PC_MAX);
    if (pc_sat_s) begin
      pc_inc_s = pc_r;
    end else begin
      pc_inc_s = pc_r + PW'(1);
    end
    // pc_inc_s doubles as the new period: PC+1, or the saturated value.
    diff_s = {1'b0, pc_inc_s} - {1'b0, {(PW - NW){1'b0}}, n_act_r};
    if (diff_s[PW]) begin
      abs_s = (PW + 1)'(0) - diff_s;
    end else begin
      abs_s = diff_s;
    end
    good_s      = (abs_s <= (PW + 1)'(TOL)) && !pc_sat_s;
    sat_event_s = (pc_r == (PC_MAX - PW'(1))) && !ref_rise_s;
  end

  // Divider counter, active ratio and registered CK_FB
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      cnt_r   <= {NW{1'b0}};
      n_act_r <= NW'(N_RST);
      ck_fb_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      n_act_r <= n_nxt_s;
      ck_fb_r <= fb_nxt_s;
    end
  end

  // Two-flop synchroniser for CK_REF plus a delay flop for edge detection
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      ref_meta_r <= 1'b0;
      ref_sync_r <= 1'b0;
      ref_dly_r  <= 1'b0;
    end else begin
      ref_meta_r <= CK_REF;
      ref_sync_r <= ref_meta_r;
      ref_dly_r  <= ref_sync_r;
    end
  end

  // Period measurement and UNLOCKED/LOCKED state machine with registered LOCK
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      pc_r     <= {PW{1'b0}};
      period_r <= {PW{1'b0}};
      armed_r  <= 1'b0;
      gc_r     <= {GW{1'b0}};
      state_r  <= UNLOCKED;
      lock_r   <= 1'b0;
    end else if (n_change_s) begin
      // A new ratio invalidates any measurement in flight; a coincident
      // reference edge still starts a fresh measurement.
      state_r <= UNLOCKED;
      lock_r  <= 1'b0;
      gc_r    <= {GW{1'b0}};
      armed_r <= ref_rise_s;
      if (ref_rise_s) begin
        pc_r <= {PW{1'b0}};
      end else begin
        pc_r <= pc_inc_s;
      end
      if (sat_event_s) begin
        period_r <= PC_MAX;
      end else begin
        period_r <= period_r;
      end
    end else if (ref_rise_s) begin
      pc_r    <= {PW{1'b0}};
      armed_r <= 1'b1;
      if (armed_r) begin
        period_r <= pc_inc_s;
        if (good_s) begin
          case (state_r)
            UNLOCKED: begin
              if (gc_r >= GW'(LOCK_CNT - 1)) begin
                gc_r    <= GW'(LOCK_CNT);
                state_r <= LOCKED;
                lock_r  <= 1'b1;
              end else begin
                gc_r <= gc_r + GW'(1);
              end
            end
            LOCKED: begin
              lock_r <= 1'b1;
            end
            default: begin
              state_r <= UNLOCKED;
              lock_r  <= 1'b0;
              gc_r    <= {GW{1'b0}};
            end
          endcase
        end else begin
          state_r <= UNLOCKED;
          lock_r  <= 1'b0;
          gc_r    <= {GW{1'b0}};
        end
      end else begin
        period_r <= period_r;
      end
    end else if (sat_event_s) begin
      // Reference has stopped: flag it now rather than waiting for an edge.
      pc_r     <= PC_MAX;
      period_r <= PC_MAX;
      armed_r  <= 1'b0;
      state_r  <= UNLOCKED;
      lock_r   <= 1'b0;
      gc_r     <= {GW{1'b0}};
    end else begin
      pc_r <= pc_inc_s;
    end
  end

  assign CK_FB  = ck_fb_r;
  assign LOCK   = lock_r;
  assign PERIOD = period_r;
  assign N_ACT  = n_act_r;

endmodule

// File: tb/tb_sun_pll_fbdiv_lock.sv
// Directed self-checking bench for sun_pll_fbdiv_lock (default parameters).
module tb_sun_pll_fbdiv_lock;

  logic       ck;
  logic       pwrup_1v8;
  logic [7:0] div_n;
  logic       ck_ref;
  logic       ck_fb;
  logic       lock;
  logic [9:0] period;
  logic [7:0] n_act;

  int   n_vec;
  int   n_err;
  logic fb_old;
  logic fb_now;

  sun_pll_fbdiv_lock dut (
    .CK       (ck),
    .PWRUP_1V8(pwrup_1v8),
    .DIV_N    (div_n),
    .CK_REF   (ck_ref),
    .CK_FB    (ck_fb),
    .LOCK     (lock),
    .PERIOD   (period),
    .N_ACT    (n_act)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // advance one CK cycle, sample 1 time unit after the rising edge
  task automatic step();
    fb_old = fb_now;
    @(posedge ck);
    #1;
    fb_now = ck_fb;
  endtask

  // wait until CK_FB falls (divider wrap); a missing fall counts as a miscompare
  task automatic wait_fall(input string name);
    int k;
    fb_now = ck_fb;
    k = 0;
    do begin
      step();
      k++;
    end while (!(fb_old && !fb_now) && k < 200);
    if (!(fb_old && !fb_now)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no CK_FB fall within 200 CK", name);
    end
  endtask

  // CK cycles until the next CK_FB fall
  task automatic count_to_fall(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(fb_old && !fb_now) && n < 200);
  endtask

  // starting on a wrap sample, count low cycles then high cycles of CK_FB
  task automatic measure_low_high(output int lo, output int hi);
    lo = 1;
    hi = 0;
    step();
    while (fb_now == 1'b0 && lo < 200) begin
      lo++;
      step();
    end
    while (fb_now == 1'b1 && hi < 200) begin
      hi++;
      step();
    end
  endtask

  // one reference period of p CK cycles, starting with a rising edge
  task automatic ref_period(input int p);
    ck_ref = 1'b1;
    #(p * 5);
    ck_ref = 1'b0;
    #(p * 5);
  endtask

  task automatic test_reset();
    pwrup_1v8 = 1'b0;
    div_n     = 8'd32;
    ck_ref    = 1'b0;
    #12;
    n_vec++; if (ck_fb !== 1'b0) begin n_err++; $display("FAIL reset_ck_fb: got %b want 0", ck_fb); end
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", lock); end
    n_vec++; if (period !== 10'd0) begin n_err++; $display("FAIL reset_period: got %0d want 0", period); end
    n_vec++; if (n_act !== 8'd32) begin n_err++; $display("FAIL reset_n_act: got %0d want 32", n_act); end
    #6;
    pwrup_1v8 = 1'b1;
  endtask

  task automatic test_divider();
    int lo, hi;
    wait_fall("div32_sync");
    measure_low_high(lo, hi);
    n_vec++; if (lo != 16) begin n_err++; $display("FAIL div32_low: got %0d want 16", lo); end
    n_vec++; if (hi != 16) begin n_err++; $display("FAIL div32_high: got %0d want 16", hi); end
    div_n = 8'd5;
    wait_fall("div5_sync");
    n_vec++; if (n_act !== 8'd5) begin n_err++; $display("FAIL div5_n_act: got %0d want 5", n_act); end
    measure_low_high(lo, hi);
    n_vec++; if (lo != 2) begin n_err++; $display("FAIL div5_low: got %0d want 2", lo); end
    n_vec++; if (hi != 3) begin n_err++; $display("FAIL div5_high: got %0d want 3", hi); end
  endtask

  task automatic test_ratio_change();
    int n;
    logic [3:0] seq;
    div_n = 8'd32;
    wait_fall("chg_sync");
    n_vec++; if (n_act !== 8'd32) begin n_err++; $display("FAIL chg_n_act32: got %0d want 32", n_act); end
    repeat (10) step();
    div_n = 8'd8;
    count_to_fall(n);
    n_vec++; if (n + 10 != 32) begin n_err++; $display("FAIL chg_keep_period: got %0d want 32", n + 10); end
    n_vec++; if (n_act !== 8'd8) begin n_err++; $display("FAIL chg_n_act8: got %0d want 8", n_act); end
    count_to_fall(n);
    n_vec++; if (n != 8) begin n_err++; $display("FAIL chg_period8: got %0d want 8", n); end
    div_n = 8'd0;
    wait_fall("clamp0_sync");
    n_vec++; if (n_act !== 8'd2) begin n_err++; $display("FAIL clamp0_n_act: got %0d want 2", n_act); end
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = fb_now;
    end
    n_vec++; if (seq !== 4'b0101 && seq !== 4'b1010) begin n_err++; $display("FAIL clamp0_toggle: got %b want 0101 or 1010", seq); end
    div_n = 8'd1;
    repeat (6) step();
    n_vec++; if (n_act !== 8'd2) begin n_err++; $display("FAIL clamp1_n_act: got %0d want 2", n_act); end
    div_n = 8'd32;
    wait_fall("restore32_sync");
    n_vec++; if (n_act !== 8'd32) begin n_err++; $display("FAIL restore_n_act: got %0d want 32", n_act); end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 16; i++) ref_period(32);
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL lock_16th_edge: got %b want 0", lock); end
    ref_period(32);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL lock_17th_edge: got %b want 1", lock); end
    n_vec++; if (period !== 10'd32) begin n_err++; $display("FAIL lock_period32: got %0d want 32", period); end
    ref_period(33);
    ref_period(33);
    ref_period(32);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL lock_tol33: got %b want 1", lock); end
    n_vec++; if (period !== 10'd33) begin n_err++; $display("FAIL lock_period33: got %0d want 33", period); end
  endtask

  task automatic test_unlock_relock();
    ref_period(35);
    ref_period(32);
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL bad35_lock: got %b want 0", lock); end
    n_vec++; if (period !== 10'd35) begin n_err++; $display("FAIL bad35_period: got %0d want 35", period); end
    for (int i = 0; i < 15; i++) ref_period(32);
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL relock_15: got %b want 0", lock); end
    ref_period(32);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL relock_16: got %b want 1", lock); end
  endtask

  task automatic test_ref_stop_and_ratio_change();
    ck_ref = 1'b0;
    #(950 * 10);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL stop_before_sat: got %b want 1", lock); end
    #(60 * 10);
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL stop_lock: got %b want 0", lock); end
    n_vec++; if (period !== 10'd1023) begin n_err++; $display("FAIL stop_period: got %0d want 1023", period); end
    ref_period(32);
    n_vec++; if (period !== 10'd1023) begin n_err++; $display("FAIL rearm_period: got %0d want 1023", period); end
    for (int i = 0; i < 16; i++) ref_period(32);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL rearm_lock: got %b want 1", lock); end
    wait_fall("ratio_sync");
    div_n = 8'd16;
    n_vec++; if (lock !== 1'b1 || n_act !== 8'd32) begin n_err++; $display("FAIL ratio_before: got lock=%b n=%0d want lock=1 n=32", lock, n_act); end
    wait_fall("ratio_wrap");
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL ratio_lock: got %b want 0", lock); end
    n_vec++; if (n_act !== 8'd16) begin n_err++; $display("FAIL ratio_n_act: got %0d want 16", n_act); end
  endtask

  task automatic test_reset_midrun();
    int n;
    n = 0;
    while (ck_fb !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    #2;
    pwrup_1v8 = 1'b0;
    #1;
    n_vec++; if (ck_fb !== 1'b0) begin n_err++; $display("FAIL mid_ck_fb: got %b want 0", ck_fb); end
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL mid_lock: got %b want 0", lock); end
    n_vec++; if (period !== 10'd0) begin n_err++; $display("FAIL mid_period: got %0d want 0", period); end
    n_vec++; if (n_act !== 8'd32) begin n_err++; $display("FAIL mid_n_act: got %0d want 32", n_act); end
    #30;
    pwrup_1v8 = 1'b1;
    n = 0;
    do begin
      @(posedge ck);
      #1;
      n++;
    end while (ck_fb !== 1'b1 && n < 100);
    n_vec++; if (n != 16) begin n_err++; $display("FAIL mid_first_rise: got %0d want 16", n); end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    fb_old = 1'b0;
    fb_now = 1'b0;
    test_reset();
    test_divider();
    test_ratio_change();
    test_lock();
    test_unlock_relock();
    test_ref_stop_and_ratio_change();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
